// File: rtl/mem_port_arbiter.sv
// Shares one single-ported fixed-latency memory between the IF fetch port and the DM data port.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: DM wins ties).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_stall_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              dm_sel_q;
  logic              if_ack_q;
  logic              dm_ack_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              any_req;
  logic              grant_dm;
  logic [ADDR_W-1:0] sel_addr;
  logic              unused_addr_lsbs;

  assign any_req  = if_req_i | dm_req_i;
  assign sel_addr = grant_dm ? dm_addr_i : if_addr_i;
  // Memory is word-addressed; the byte offset is dropped at grant.
  assign unused_addr_lsbs = ^sel_addr[1:0];

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dm_q;

  // On a tie, the port that was not granted last wins; reset value IF lets DM win first.
  assign grant_dm = dm_req_i & (~if_req_i | ~last_dm_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_dm_q <= 1'b0;
    end else if (state_q == S_IDLE && any_req) begin
      last_dm_q <= grant_dm;
    end
  end
`else
  assign grant_dm = dm_req_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dm_sel_q    <= 1'b0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            dm_sel_q    <= grant_dm;
            mem_addr_q  <= {sel_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_q <= grant_dm ? dm_wdata_i : '0;
            mem_we_q    <= grant_dm & dm_we_i;
            mem_en_q    <= 1'b1;
            cnt_q       <= CNT_W'(MEM_LAT - 1);
            state_q     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt_q == '0) begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            state_q  <= S_RESP;
            if (dm_sel_q) begin
              dm_ack_q   <= 1'b1;
              dm_rdata_q <= mem_we_q ? '0 : mem_rdata_i;
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= mem_rdata_i;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        // Ack is visible this cycle; the following IDLE cycle is the mandatory bubble.
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_stall_o  = if_req_i & ~if_ack_q;
  assign dm_stall_o  = dm_req_i & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level model (slot timing + word memory array).
module tb_mem_port_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned LAT   = 2;
  localparam int unsigned LAT3  = 3;
  localparam int          NRAND = 600;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          if_req, if_ack, if_stall;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_ack, dm_stall;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          t6_if_req, t6_if_ack, t6_if_stall;
  logic [AW-1:0] t6_if_addr;
  logic [DW-1:0] t6_if_rdata;
  logic          t6_dm_req, t6_dm_we, t6_dm_ack, t6_dm_stall;
  logic [AW-1:0] t6_dm_addr;
  logic [DW-1:0] t6_dm_wdata, t6_dm_rdata;
  logic          t6_mem_en, t6_mem_we;
  logic [AW-1:0] t6_mem_addr;
  logic [DW-1:0] t6_mem_wdata, t6_mem_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
    .if_stall_o(if_stall),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata), .dm_stall_o(dm_stall),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT3)) u_dut_lat3 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(t6_if_req), .if_addr_i(t6_if_addr), .if_ack_o(t6_if_ack),
    .if_rdata_o(t6_if_rdata), .if_stall_o(t6_if_stall),
    .dm_req_i(t6_dm_req), .dm_we_i(t6_dm_we), .dm_addr_i(t6_dm_addr),
    .dm_wdata_i(t6_dm_wdata), .dm_ack_o(t6_dm_ack), .dm_rdata_o(t6_dm_rdata),
    .dm_stall_o(t6_dm_stall),
    .mem_en_o(t6_mem_en), .mem_we_o(t6_mem_we), .mem_addr_o(t6_mem_addr),
    .mem_wdata_o(t6_mem_wdata), .mem_rdata_i(t6_mem_rdata)
  );

  // Behavioural memory attached to the main instance.
  logic [DW-1:0] tbmem [16];
  logic          mem_init, mem_override;
  logic [DW-1:0] override_val;

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'h3C00_0000 ^ (32'(i) * 32'h0101_0107);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) tbmem[i] <= init_word(i);
    end else if (mem_en && mem_we) begin
      tbmem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  assign mem_rdata = mem_override ? override_val : tbmem[mem_addr[5:2]];

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_if_rd, exp_dm_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_if_rd = '0;
    exp_dm_rd = '0;
  endtask

  typedef struct packed {
    logic          dm;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mrd;
    logic [AW-1:0] exp_addr;
    logic          exp_we;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs [6];

  // Single isolated access; inputs are scrambled after grant to prove the latched copy is used.
  task automatic run_vec(input vec_t v, input int idx);
    mem_override = 1'b1;
    override_val = v.mrd;
    dm_we    = v.we;
    dm_wdata = v.wdata;
    if (v.dm) begin
      dm_req  = 1'b1;
      dm_addr = v.addr;
    end else begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end
    tick();
    dm_addr  = ~v.addr;
    if_addr  = ~v.addr;
    dm_wdata = ~v.wdata;
    dm_we    = ~v.we;
    for (int c = 0; c < int'(LAT); c++) begin
      chk1($sformatf("vec%0d_mem_en", idx), mem_en, 1'b1);
      chk1($sformatf("vec%0d_mem_we", idx), mem_we, v.exp_we);
      chk($sformatf("vec%0d_mem_addr", idx), mem_addr, v.exp_addr);
      if (v.exp_we) chk($sformatf("vec%0d_mem_wdata", idx), mem_wdata, v.wdata);
      chk1($sformatf("vec%0d_if_ack_early", idx), if_ack, 1'b0);
      chk1($sformatf("vec%0d_dm_ack_early", idx), dm_ack, 1'b0);
      chk1($sformatf("vec%0d_stall", idx), v.dm ? dm_stall : if_stall, 1'b1);
      tick();
    end
    if (v.dm) exp_dm_rd = v.exp_rd;
    else      exp_if_rd = v.exp_rd;
    chk1($sformatf("vec%0d_if_ack", idx), if_ack, ~v.dm);
    chk1($sformatf("vec%0d_dm_ack", idx), dm_ack, v.dm);
    chk($sformatf("vec%0d_if_rdata", idx), if_rdata, exp_if_rd);
    chk($sformatf("vec%0d_dm_rdata", idx), dm_rdata, exp_dm_rd);
    chk1($sformatf("vec%0d_ack_mem_en", idx), mem_en, 1'b0);
    chk1($sformatf("vec%0d_ack_if_stall", idx), if_stall, 1'b0);
    chk1($sformatf("vec%0d_ack_dm_stall", idx), dm_stall, 1'b0);
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
    chk1($sformatf("vec%0d_post_ack", idx), if_ack | dm_ack, 1'b0);
    chk1($sformatf("vec%0d_post_en", idx), mem_en, 1'b0);
  endtask

  // Transaction-level reference model state for the random run.
  logic [DW-1:0] model_mem [16];
  int            free_at, m_gnt;
  bit            m_act, m_dm, m_we, last_dm, gdm;
  logic [AW-1:0] m_addr, a_sel;
  logic [DW-1:0] m_wdata, m_rd;
  bit            if_wait, dm_wait, exp_en, ack_now, e_if_ack, e_dm_ack;
  bit            exp_order [4];

  initial begin
    rst = 1'b1;
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    t6_if_req = 0; t6_if_addr = '0; t6_dm_req = 0; t6_dm_we = 0; t6_dm_addr = '0;
    t6_dm_wdata = '0; t6_mem_rdata = 32'hCAFE_0003;
    mem_init = 0; mem_override = 1; override_val = '0;
    exp_if_rd = '0; exp_dm_rd = '0;

    // Reset state
    repeat (3) tick();
    chk1("rst_if_ack", if_ack, 1'b0);
    chk1("rst_dm_ack", dm_ack, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    chk1("rst_stall", if_stall | dm_stall, 1'b0);
    rst = 1'b0;
    tick();

    // Directed single-access vectors
    vecs[0] = '{dm:1, we:0, addr:32'h0000_0004, wdata:32'h0, mrd:32'h1234_5678,
                exp_addr:32'h0000_0004, exp_we:0, exp_rd:32'h1234_5678};
    vecs[1] = '{dm:1, we:1, addr:32'h0000_000B, wdata:32'h5, mrd:32'hFFFF_FFFF,
                exp_addr:32'h0000_0008, exp_we:1, exp_rd:32'h0};
    vecs[2] = '{dm:0, we:0, addr:32'h0000_1003, wdata:32'h0, mrd:32'hA5A5_0001,
                exp_addr:32'h0000_1000, exp_we:0, exp_rd:32'hA5A5_0001};
    vecs[3] = '{dm:0, we:0, addr:32'hFFFF_FFFF, wdata:32'h0, mrd:32'h0BAD_F00D,
                exp_addr:32'hFFFF_FFFC, exp_we:0, exp_rd:32'h0BAD_F00D};
    vecs[4] = '{dm:1, we:1, addr:32'h8000_0006, wdata:32'hDEAD_BEEF, mrd:32'h7777_7777,
                exp_addr:32'h8000_0004, exp_we:1, exp_rd:32'h0};
    vecs[5] = '{dm:0, we:1, addr:32'h0000_0040, wdata:32'h9, mrd:32'h0000_0001,
                exp_addr:32'h0000_0040, exp_we:0, exp_rd:32'h0000_0001};
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Both ports held: tie order and MEM_LAT+2 spacing
    if (RR_EN) exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
    else       exp_order = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    begin
      int k = 0;
      int cyc = 0;
      int last_ack = -1;
      override_val = 32'h0000_0333;
      if_req = 1; if_addr = 32'h100; dm_req = 1; dm_we = 0; dm_addr = 32'h200;
      while (k < 4 && cyc < 40) begin
        tick();
        cyc++;
        if (if_ack || dm_ack) begin
          chk1($sformatf("t3_one_ack%0d", k), if_ack & dm_ack, 1'b0);
          chk1($sformatf("t3_winner%0d", k), dm_ack, exp_order[k]);
          if (last_ack >= 0) chk($sformatf("t3_gap%0d", k), 32'(cyc - last_ack), 32'(LAT + 2));
          last_ack = cyc;
          k++;
          if (!RR_EN && k == 3) dm_req = 0;
        end
      end
      chk("t3_count", 32'(k), 32'd4);
      if_req = 0; dm_req = 0;
      repeat (LAT + 3) tick();
    end

    // Reset during the first ACCESS cycle of a write, then reissue
    do_reset();
    dm_req = 1; dm_we = 1; dm_addr = 32'h20; dm_wdata = 32'hAA;
    tick();
    chk1("t4_pre_en", mem_en, 1'b1);
    chk1("t4_pre_we", mem_we, 1'b1);
    rst = 1;
    tick();
    rst = 0;
    chk1("t4_rst_en", mem_en, 1'b0);
    chk1("t4_rst_we", mem_we, 1'b0);
    chk1("t4_rst_ack", dm_ack, 1'b0);
    for (int c = 1; c <= int'(LAT) + 1; c++) begin
      tick();
      chk1($sformatf("t4_ack_c%0d", c), dm_ack, c == int'(LAT) + 1);
      chk1($sformatf("t4_en_c%0d", c), mem_en, c <= int'(LAT));
    end
    chk("t4_rdata", dm_rdata, 32'h0);
    dm_req = 0;
    tick();

    // IF request dropped during ACCESS: exactly one ack, no regrant
    do_reset();
    override_val = 32'h5555_AAAA;
    if_req = 1; if_addr = 32'h44;
    tick();
    if_req = 0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk1($sformatf("t5_ack_c%0d", c), if_ack, c == int'(LAT));
      chk1($sformatf("t5_en_c%0d", c), mem_en, c < int'(LAT));
      if (c == int'(LAT)) chk("t5_rdata", if_rdata, 32'h5555_AAAA);
    end

    // MEM_LAT=3 instance: stall profile, ack cycle, idle bubble, next grant
    do_reset();
    t6_if_req = 1; t6_if_addr = 32'h100;
    begin
      bit st [6];
      bit ak [6];
      bit en [6];
      st = '{1, 1, 1, 0, 1, 1};
      ak = '{0, 0, 0, 1, 0, 0};
      en = '{1, 1, 1, 0, 0, 1};
      for (int c = 0; c < 6; c++) begin
        tick();
        chk1($sformatf("t6_stall_c%0d", c), t6_if_stall, st[c]);
        chk1($sformatf("t6_ack_c%0d", c), t6_if_ack, ak[c]);
        chk1($sformatf("t6_en_c%0d", c), t6_mem_en, en[c]);
        if (c == 3) chk("t6_rdata", t6_if_rdata, 32'hCAFE_0003);
      end
    end
    t6_if_req = 0;
    repeat (6) tick();

    // Randomized traffic against the transaction-level model
    mem_override = 0;
    mem_init = 1;
    tick();
    mem_init = 0;
    for (int i = 0; i < 16; i++) model_mem[i] = init_word(i);
    do_reset();
    free_at = 0; m_act = 0; m_gnt = 0; m_dm = 0; m_we = 0; last_dm = 0;
    m_addr = '0; m_wdata = '0; m_rd = '0; if_wait = 0; dm_wait = 0;
    for (int n = 0; n < NRAND; n++) begin
      @(posedge clk);
      if (n >= free_at && (if_req || dm_req)) begin
        gdm     = dm_req && !(if_req && RR_EN && last_dm);
        m_act   = 1; m_gnt = n; m_dm = gdm; free_at = n + int'(LAT) + 2;
        m_we    = gdm && dm_we;
        a_sel   = gdm ? dm_addr : if_addr;
        m_addr  = {a_sel[AW-1:2], 2'b00};
        m_wdata = dm_wdata;
        m_rd    = m_we ? '0 : model_mem[m_addr[5:2]];
        if (m_we) model_mem[m_addr[5:2]] = m_wdata;
        last_dm = gdm;
        if (gdm) dm_wait = 1; else if_wait = 1;
      end
      #1;
      exp_en   = m_act && n >= m_gnt && n < m_gnt + int'(LAT);
      ack_now  = m_act && n == m_gnt + int'(LAT);
      e_if_ack = ack_now && !m_dm;
      e_dm_ack = ack_now && m_dm;
      if (e_if_ack) exp_if_rd = m_rd;
      if (e_dm_ack) exp_dm_rd = m_rd;
      chk1("rnd_if_ack", if_ack, e_if_ack);
      chk1("rnd_dm_ack", dm_ack, e_dm_ack);
      chk("rnd_if_rdata", if_rdata, exp_if_rd);
      chk("rnd_dm_rdata", dm_rdata, exp_dm_rd);
      chk1("rnd_mem_en", mem_en, exp_en);
      chk1("rnd_mem_we", mem_we, exp_en && m_we);
      if (exp_en) chk("rnd_mem_addr", mem_addr, m_addr);
      if (exp_en && m_we) chk("rnd_mem_wdata", mem_wdata, m_wdata);
      chk1("rnd_if_stall", if_stall, if_req && !e_if_ack);
      chk1("rnd_dm_stall", dm_stall, dm_req && !e_dm_ack);

      if (e_if_ack) begin
        if_wait = 0;
        if_req  = ($urandom_range(3) == 0);
        if_addr = $urandom;
      end else if (!if_req && !if_wait) begin
        if ($urandom_range(2) == 0) begin
          if_req  = 1;
          if_addr = $urandom;
        end
      end else if (if_req && if_wait) begin
        if ($urandom_range(7) == 0) if_req = 0;
        else if ($urandom_range(3) == 0) if_addr = $urandom;
      end

      if (e_dm_ack) begin
        dm_wait  = 0;
        dm_req   = ($urandom_range(3) == 0);
        dm_we    = $urandom_range(1) == 1;
        dm_addr  = $urandom;
        dm_wdata = $urandom;
      end else if (!dm_req && !dm_wait) begin
        if ($urandom_range(2) == 0) begin
          dm_req   = 1;
          dm_we    = $urandom_range(1) == 1;
          dm_addr  = $urandom;
          dm_wdata = $urandom;
        end
      end else if (dm_req && dm_wait) begin
        if ($urandom_range(7) == 0) dm_req = 0;
        else if ($urandom_range(3) == 0) begin
          dm_addr  = $urandom;
          dm_wdata = $urandom;
          dm_we    = ~dm_we;
        end
      end
    end
    if_req = 0;
    dm_req = 0;
    repeat (LAT + 3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
